// File: rtl/decode_queue.sv
// decode_queue: buffered ARM instruction decoder.
//   Fetched instructions enter a DEPTH-entry FIFO over a valid/ready handshake.
//   The FIFO head is popped into a registered output stage once the NZCV flags
//   are architecturally current; at that edge the condition is evaluated, the
//   instruction is classified and its immediate and branch target are expanded.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      fetch handshake (in_ready registered, = FIFO not full)
//   in_instr, in_pc        instruction word and its address
//   flags, flags_valid     live NZCV = {N,Z,C,V}; pop stalls while flags_valid=0
//   flush                  synchronous discard of FIFO and output stage
//   out_valid/out_ready    consumer handshake
//   out_instr, out_pc      raw instruction and address
//   out_class              0 DP, 1 MUL, 2 SDT, 3 BDT, 4 BRANCH, 5 SWI, 7 UNDEF
//   out_cond_pass          condition satisfied
//   out_rn, out_rd         instr[19:16], instr[15:12]
//   out_imm, out_target    expanded immediate, pc + 8 + sext(off24) << 2
//   out_count              deliveries since reset/flush (wraps)
module decode_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [3:0]        flags,
  input  logic              flags_valid,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [2:0]        out_class,
  output logic              out_cond_pass,
  output logic [3:0]        out_rn,
  output logic [3:0]        out_rd,
  output logic [31:0]       out_imm,
  output logic [ADDR_W-1:0] out_target,
  output logic [15:0]       out_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  localparam logic [2:0] CLS_DP     = 3'd0;
  localparam logic [2:0] CLS_MUL    = 3'd1;
  localparam logic [2:0] CLS_SDT    = 3'd2;
  localparam logic [2:0] CLS_BDT    = 3'd3;
  localparam logic [2:0] CLS_BRANCH = 3'd4;
  localparam logic [2:0] CLS_SWI    = 3'd5;
  localparam logic [2:0] CLS_UNDEF  = 3'd7;

  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    n = nzcv[3]; z = nzcv[2]; c = nzcv[1]; v = nzcv[0];
    case (cond)
      4'h0: cond_check = z;
      4'h1: cond_check = !z;
      4'h2: cond_check = c;
      4'h3: cond_check = !c;
      4'h4: cond_check = n;
      4'h5: cond_check = !n;
      4'h6: cond_check = v;
      4'h7: cond_check = !v;
      4'h8: cond_check = c && !z;
      4'h9: cond_check = !c || z;
      4'hA: cond_check = (n == v);
      4'hB: cond_check = (n != v);
      4'hC: cond_check = !z && (n == v);
      4'hD: cond_check = z || (n != v);
      4'hE: cond_check = 1'b1;
      default: cond_check = 1'b0;  // 1111: never-execute / unconditional space
    endcase
  endfunction

  function automatic logic [2:0] classify(input logic [31:0] instr);
    if (instr[31:28] == 4'hF) begin
      classify = CLS_UNDEF;
    end else begin
      case (instr[27:25])
        3'b000: classify = (instr[24:22] == 3'b000 && instr[7:4] == 4'b1001) ? CLS_MUL : CLS_DP;
        3'b001: classify = CLS_DP;
        3'b010: classify = CLS_SDT;
        3'b011: classify = CLS_SDT;
        3'b100: classify = CLS_BDT;
        3'b101: classify = CLS_BRANCH;
        3'b111: classify = instr[24] ? CLS_SWI : CLS_UNDEF;
        default: classify = CLS_UNDEF;
      endcase
    end
  endfunction

  function automatic logic [31:0] imm_expand(input logic [31:0] instr, input logic [2:0] cls);
    logic [63:0] dbl;
    logic [4:0]  rot;
    dbl = {instr[7:0], 24'd0, instr[7:0], 24'd0} >> 24;  // {0..,imm8,0..,imm8}
    rot = {instr[11:8], 1'b0};
    dbl = {32'd0, instr[7:0] == 8'd0 ? 32'd0 : {24'd0, instr[7:0]}};
    dbl = {dbl[31:0], dbl[31:0]} >> rot;                  // rotate right by 2*rot4
    case (cls)
      CLS_DP:     imm_expand = instr[25] ? dbl[31:0] : 32'd0;
      CLS_SDT:    imm_expand = instr[25] ? 32'd0 : {20'd0, instr[11:0]};
      CLS_BRANCH: imm_expand = {{6{instr[23]}}, instr[23:0], 2'b00};
      default:    imm_expand = 32'd0;
    endcase
  endfunction

  logic [31:0]       mem_instr_r [DEPTH];
  logic [ADDR_W-1:0] mem_pc_r    [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r, wr_nxt_s, rd_nxt_s;
  logic              in_ready_r, empty_s, push_s, pop_s, full_nxt_s;
  logic [31:0]       head_instr_s;
  logic [ADDR_W-1:0] head_pc_s, head_target_s;
  logic [2:0]        head_class_s;

  // FIFO control: handshakes, next pointers and next-state fullness.
  always_comb begin
    empty_s      = (wr_ptr_r == rd_ptr_r);
    push_s       = in_valid && in_ready_r && !flush;
    pop_s        = !empty_s && flags_valid && (!out_valid || out_ready) && !flush;
    wr_nxt_s     = flush ? '0 : (push_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r);
    rd_nxt_s     = flush ? '0 : (pop_s ? rd_ptr_r + PTR_W'(1) : rd_ptr_r);
    full_nxt_s   = (wr_nxt_s[IDX_W] != rd_nxt_s[IDX_W]) &&
                   (wr_nxt_s[IDX_W-1:0] == rd_nxt_s[IDX_W-1:0]);
    head_instr_s = mem_instr_r[rd_ptr_r[IDX_W-1:0]];
    head_pc_s    = mem_pc_r[rd_ptr_r[IDX_W-1:0]];
    head_class_s = classify(head_instr_s);
    head_target_s = head_pc_s + ADDR_W'(32'd8) +
                    ({{(ADDR_W-24){head_instr_s[23]}}, head_instr_s[23:0]} << 2);
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_instr_r[wr_ptr_r[IDX_W-1:0]] <= in_instr;
      mem_pc_r[wr_ptr_r[IDX_W-1:0]]    <= in_pc;
    end
  end

  // FIFO pointers and registered in_ready derived from next occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      in_ready_r <= 1'b1;
    end else begin
      wr_ptr_r   <= wr_nxt_s;
      rd_ptr_r   <= rd_nxt_s;
      in_ready_r <= !full_nxt_s;
    end
  end

  // Output stage: load decoded head on pop, drop on consume, count deliveries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_instr     <= 32'd0;
      out_pc        <= '0;
      out_class     <= 3'd0;
      out_cond_pass <= 1'b0;
      out_rn        <= 4'd0;
      out_rd        <= 4'd0;
      out_imm       <= 32'd0;
      out_target    <= '0;
      out_count     <= 16'd0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_count <= 16'd0;
    end else begin
      if (out_valid && out_ready) begin
        out_count <= out_count + 16'd1;
      end
      if (pop_s) begin
        out_valid     <= 1'b1;
        out_instr     <= head_instr_s;
        out_pc        <= head_pc_s;
        out_class     <= head_class_s;
        out_cond_pass <= cond_check(head_instr_s[31:28], flags);
        out_rn        <= head_instr_s[19:16];
        out_rd        <= head_instr_s[15:12];
        out_imm       <= imm_expand(head_instr_s, head_class_s);
        out_target    <= head_target_s;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign in_ready = in_ready_r;

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed decode vectors, backpressure,
// flags_valid stall, in-order delivery and flush behaviour.
module tb_decode_queue;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  logic              clk, rst_n;
  logic              in_valid, in_ready, flags_valid, flush, out_valid, out_ready;
  logic [31:0]       in_instr, out_instr, out_imm;
  logic [ADDR_W-1:0] in_pc, out_pc, out_target;
  logic [3:0]        flags, out_rn, out_rd;
  logic [2:0]        out_class;
  logic              out_cond_pass;
  logic [15:0]       out_count;

  int n_checks = 0;
  int n_errors = 0;

  decode_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flags(flags), .flags_valid(flags_valid),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_class(out_class),
    .out_cond_pass(out_cond_pass), .out_rn(out_rn), .out_rd(out_rd),
    .out_imm(out_imm), .out_target(out_target), .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Push one word with out_ready=1 and wait (bounded) until it is in the output stage.
  task automatic run_one(input logic [31:0] instr, input logic [31:0] pc, input logic [3:0] fl);
    bit got;
    @(negedge clk);
    in_valid = 1'b1; in_instr = instr; in_pc = pc; flags = fl;
    @(negedge clk);
    in_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      if (out_valid) got = 1'b1;
      else @(negedge clk);
    end
    check_eq("out_valid_timeout", {63'd0, got}, 64'd1);
  endtask

  task automatic push_word(input logic [31:0] instr);
    @(negedge clk);
    in_valid = 1'b1; in_instr = instr; in_pc = 32'h0;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  logic [31:0] exp_q [5];
  int          k;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0;
    flags = 4'd0; flags_valid = 1'b1; flush = 1'b0; out_ready = 1'b1;
    #22;
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_out_count", {48'd0, out_count}, 64'd0);
    check_eq("rst_out_imm", {32'd0, out_imm}, 64'd0);
    check_eq("rst_out_class", {61'd0, out_class}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Decode vectors
    run_one(32'hE3A000FF, 32'h0, 4'b0000);
    check_eq("mov_class", {61'd0, out_class}, 64'd0);
    check_eq("mov_pass", {63'd0, out_cond_pass}, 64'd1);
    check_eq("mov_rd", {60'd0, out_rd}, 64'd0);
    check_eq("mov_imm", {32'd0, out_imm}, 64'h0000_00FF);
    run_one(32'hE3A004FF, 32'h4, 4'b0000);
    check_eq("mov_rot_imm", {32'd0, out_imm}, 64'hFF00_0000);
    run_one(32'hEA000002, 32'h100, 4'b0000);
    check_eq("b_class", {61'd0, out_class}, 64'd4);
    check_eq("b_pass", {63'd0, out_cond_pass}, 64'd1);
    check_eq("b_target", {32'd0, out_target}, 64'h110);
    check_eq("b_pc", {32'd0, out_pc}, 64'h100);
    run_one(32'hEAFFFFFE, 32'h100, 4'b0000);
    check_eq("bneg_target", {32'd0, out_target}, 64'h100);
    check_eq("bneg_imm", {32'd0, out_imm}, 64'hFFFF_FFF8);
    run_one(32'h0A000000, 32'h0, 4'b0000);
    check_eq("beq_z0_class", {61'd0, out_class}, 64'd4);
    check_eq("beq_z0_pass", {63'd0, out_cond_pass}, 64'd0);
    run_one(32'h0A000000, 32'h0, 4'b0100);
    check_eq("beq_z1_pass", {63'd0, out_cond_pass}, 64'd1);
    run_one(32'hF0000000, 32'h0, 4'b0000);
    check_eq("nv_class", {61'd0, out_class}, 64'd7);
    check_eq("nv_pass", {63'd0, out_cond_pass}, 64'd0);
    run_one(32'hE5910004, 32'h0, 4'b0000);
    check_eq("ldr_class", {61'd0, out_class}, 64'd2);
    check_eq("ldr_rn", {60'd0, out_rn}, 64'd1);
    check_eq("ldr_rd", {60'd0, out_rd}, 64'd0);
    check_eq("ldr_imm", {32'd0, out_imm}, 64'd4);
    run_one(32'hE0010392, 32'h0, 4'b0000);
    check_eq("mul_class", {61'd0, out_class}, 64'd1);
    run_one(32'hEF000000, 32'h0, 4'b0000);
    check_eq("swi_class", {61'd0, out_class}, 64'd5);
    run_one(32'hE8BD8000, 32'h0, 4'b0000);
    check_eq("bdt_class", {61'd0, out_class}, 64'd3);
    run_one(32'hC0000000, 32'h0, 4'b1001);  // GT, N=V=1, Z=0 -> pass
    check_eq("gt_pass", {63'd0, out_cond_pass}, 64'd1);
    run_one(32'h80000000, 32'h0, 4'b0110);  // HI, C=1, Z=1 -> fail
    check_eq("hi_pass", {63'd0, out_cond_pass}, 64'd0);

    // Clear the delivery count, then fill with out_ready low
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush_count", {48'd0, out_count}, 64'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) exp_q[i] = 32'hE1A00000 + i;
    for (int i = 0; i < 4; i++) push_word(exp_q[i]);
    @(negedge clk);
    check_eq("ready_after4", {63'd0, in_ready}, 64'd1);
    push_word(exp_q[4]);
    @(negedge clk);
    check_eq("ready_after5", {63'd0, in_ready}, 64'd0);
    // Offer a word while full: it must never be accepted
    in_valid = 1'b1; in_instr = 32'hDEADBEEF;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("hold_head_instr", {32'd0, out_instr}, {32'd0, exp_q[0]});

    // flags_valid low: output drains but the head is held
    flags_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check_eq("fv0_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("fv0_count", {48'd0, out_count}, 64'd1);
    @(negedge clk);
    check_eq("fv0_still_empty", {63'd0, out_valid}, 64'd0);
    check_eq("fv0_in_ready", {63'd0, in_ready}, 64'd0);
    flags_valid = 1'b1;
    k = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        if (k < 5) check_eq("order", {32'd0, out_instr}, {32'd0, exp_q[k]});
        else check_eq("extra_word", {32'd0, out_instr}, 64'd0);
        k++;
      end
    end
    check_eq("delivered", k, 64'd5);
    check_eq("count5", {48'd0, out_count}, 64'd5);

    // Flush with 3 queued entries and a simultaneous push
    out_ready = 1'b0;
    push_word(32'h11111111);
    push_word(32'h22222222);
    push_word(32'h33333333);
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h44444444; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check_eq("fl_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("fl_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("fl_count", {48'd0, out_count}, 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("fl_no_output", {63'd0, out_valid}, 64'd0);
    end
    run_one(32'h55555555, 32'h0, 4'b0000);
    check_eq("post_flush_word", {32'd0, out_instr}, 64'h5555_5555);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised successor to the single-instruction ARM decoder. It accepts fetched ARM instructions on a valid/ready handshake and buffers them in a DEPTH-entry FIFO. Each instruction is condition-checked against live NZCV flags, classified, and its immediate and branch target are expanded. Results go to a registered output stage with its own valid/ready handshake. It sits between fetch and the ALU/SDT/branch units and replaces the old per-instruction busy/3-cycle protocol with a 1-instruction-per-cycle pipeline.

## Interface
- DEPTH, 4, FIFO entries (power of 2, ≥2)
- ADDR_W, 32, PC/target width (≥26)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  fetch presents instruction
- in_ready  output  1  queue can accept (registered, = FIFO not full)
- in_instr  input  32  instruction word
- in_pc  input  ADDR_W  address of in_instr
- flags  input  4  NZCV = {N,Z,C,V}
- flags_valid  input  1  flags are architecturally current; pop stalls while 0
- flush  input  1  synchronous discard of all queued and output-stage instructions
- out_valid  output  1  output stage holds a decoded instruction
- out_ready  input  1  consumer accepts output
- out_instr  output  32  raw instruction
- out_pc  output  ADDR_W  its address
- out_class  output  3  0 DP, 1 MUL, 2 SDT, 3 BDT, 4 BRANCH, 5 SWI, 7 UNDEF
- out_cond_pass  output  1  condition satisfied
- out_rn, out_rd  output  4 each  instr[19:16], instr[15:12]
- out_imm  output  32  expanded immediate
- out_target  output  ADDR_W  branch target
- out_count  output  16  instructions delivered since reset/flush, wraps

## Operation
- Push on in_valid & in_ready, unless flush is high (the push is dropped).
- Pop FIFO head into output stage when FIFO non-empty, flags_valid=1, and (out_valid=0 or out_ready=1). Decode and condition check use flags sampled at the pop edge.
- Condition (instr[31:28]): EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 → pass=0, class UNDEF.
- Class by instr[27:25]: 000 with instr[24:22]=000 and instr[7:4]=1001 → MUL; other 000/001 → DP; 010/011 → SDT; 100 → BDT; 101 → BRANCH; 111 with instr[24]=1 → SWI; else UNDEF.
- Failed-condition instructions are still delivered with out_cond_pass=0; the consumer decides (branch units need the not-taken indication).
- out_imm: DP with I=1 → instr[7:0] rotated right by 2*instr[11:8]; SDT with I=0 → zero-extended instr[11:0]; BRANCH → sign-extended instr[23:0]<<2; otherwise 0.
- out_target = in_pc + 8 + (sext(instr[23:0])<<2), modulo 2^ADDR_W, for every class (don't-care unless BRANCH).
- out_count increments on each out_valid & out_ready.
- flush: clears FIFO pointers, out_valid, and out_count next edge; overrides simultaneous push/pop.

## Timing
- Reset (async assert, sync-safe deassert): in_ready=1, out_valid=0, out_count=0, all out_* data fields 0, FIFO empty.
- Latency: instruction accepted at edge N is poppable at edge N+1; out_valid at N+1 at the earliest. No bypass.
- Throughput: 1 instruction/cycle with out_ready=1 and flags_valid=1.
- in_ready depends only on registered occupancy. Push when full is impossible. Simultaneous push+pop when full is not allowed (in_ready=0).
- Capacity: DEPTH in FIFO + 1 in output stage.
- out_* fields stable while out_valid=1 and out_ready=0.
- Pointer wrap: log2(DEPTH)+1-bit pointers; full = MSBs differ and rest equal.
- Reset mid-operation: all contents lost, no partial output.

## Test plan
- Reset, push 0xE3A000FF @pc 0x0, flags 0 → after 2 cycles out_class=0, pass=1, rd=0, imm=0x000000FF; 0xE3A004FF → imm=0xFF000000.
- 0xEA000002 @0x100 → class 4, pass=1, target 0x110; 0xEAFFFFFE @0x100 → target 0x100, imm=0xFFFFFFF8.
- 0x0A000000 with Z=0 → class 4, pass=0; same with flags=4'b0100 → pass=1; 0xF0000000 → class 7, pass=0.
- 0xE5910004 → class 2, rn=1, rd=0, imm=4; 0xE0010392 → class 1; 0xEF000000 → class 5; 0xE8BD8000 → class 3.
- out_ready=0, push DEPTH+1 instructions → in_ready=0 after the 5th (DEPTH=4). Release out_ready → in-order delivery, out_count=5. flags_valid=0 holds the head.
- Queue 3 entries, assert flush together with in_valid → next cycle out_valid=0, in_ready=1, out_count=0, flushed and dropped words never appear.
